counter_seq_ctrl: RTL and testbench
===================================

COUNTER_SEQ_CTRL -- requirements
Module: counter_seq_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the controlled counter width and the command data width.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-004 The block SHALL have port cmd_valid, input, 1 bit: a command is offered.
REQ-005 The block SHALL have port cmd_ready, output, 1 bit: the controller accepts a command this cycle.
REQ-006 The block SHALL have port cmd_op, input, 2 bits: 00 CLEAR, 01 LOAD, 10 RUN, 11 reserved.
REQ-007 The block SHALL have port cmd_data, input, DATA_WIDTH bits: the load value (LOAD) or the target value (RUN).
REQ-008 The block SHALL have port cmd_dir, input, 1 bit: RUN direction, 1 = up, 0 = down.
REQ-009 The block SHALL have port abort, input, 1 bit: terminates a RUN in progress.
REQ-010 The block SHALL have port cnt_q, input, DATA_WIDTH bits: the current value of the controlled counter.
REQ-011 The block SHALL have port cnt_clear, output, 1 bit: synchronous clear strobe to the counter.
REQ-012 The block SHALL have port cnt_load, output, 1 bit: synchronous load strobe to the counter.
REQ-013 The block SHALL have port cnt_load_val, output, DATA_WIDTH bits: the value to load.
REQ-014 The block SHALL have port cnt_up_down, output, 1 bit: count direction, 1 = up.
REQ-015 The block SHALL have port cnt_en, output, 1 bit: count enable to the counter.
REQ-016 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-017 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-018 The block SHALL have port status, output, 2 bits: 00 OK, 01 ABORTED, 10 BAD_OP; valid while done = 1.

Function
REQ-019 The FSM SHALL have exactly the states IDLE, CLEAR, LOAD, RUN and DONE.
REQ-020 cmd_ready SHALL equal 1 only in IDLE; a command is accepted on the edge where cmd_valid and cmd_ready are both 1.
REQ-021 On acceptance the block SHALL latch cmd_data and cmd_dir into internal registers, then move to:
  - CLEAR for op 00;
  - LOAD for op 01;
  - RUN for op 10;
  - DONE with status BAD_OP for op 11.
REQ-022 CLEAR SHALL last one cycle with cnt_clear = 1, then move to DONE with status OK.
REQ-023 LOAD SHALL last one cycle with cnt_load = 1 and cnt_load_val = the latched data, then move to DONE with status OK.
REQ-024 cnt_load_val SHALL hold the last latched data in all states.
REQ-025 In RUN, cnt_up_down SHALL equal the latched direction.
REQ-026 In RUN, cnt_en SHALL be driven combinationally as 1 if cnt_q != target, else 0, so that the counter never passes the target.
REQ-027 RUN SHALL move to DONE with status OK on the first clock edge where cnt_q == target.
REQ-028 When the target equals cnt_q on entry to RUN, the block SHALL produce no enable cycles and SHALL move to DONE on the next edge.
REQ-029 RUN SHALL count through wrap-around: up from 2^W-1 to 0, down from 0 to 2^W-1.
REQ-030 A RUN SHALL therefore last at most 2^W-1 enable cycles.
REQ-031 abort = 1 in RUN SHALL force cnt_en = 0 in that cycle and move to DONE with status ABORTED.
REQ-032 If abort and cnt_q == target occur in the same cycle, status SHALL be OK.
REQ-033 abort SHALL be ignored outside RUN.
REQ-034 DONE SHALL last exactly one cycle with done = 1, then return to IDLE.
REQ-035 status SHALL hold its value until the next DONE.
REQ-036 cnt_clear, cnt_load and cnt_en SHALL be mutually exclusive and SHALL be 0 in IDLE and DONE.
REQ-037 Command latency SHALL be as follows, counting from the accept edge:
  - CLEAR and LOAD: strobe in cycle +1, done in cycle +2;
  - RUN of N steps: done in cycle N+2.
REQ-038 cmd_valid SHALL have no effect while busy; the block SHALL not queue commands.

Reset
REQ-039 When rst_n = 0 at a clock edge, the block SHALL go to IDLE regardless of the current state, including mid-RUN.
REQ-040 Reset values SHALL be:
  - cnt_clear, cnt_load, cnt_en, done, busy = 0;
  - cnt_load_val = 0;
  - cnt_up_down = 1;
  - status = 00;
  - latched target = 0, latched direction = 1.
REQ-041 cmd_ready SHALL be 0 while rst_n = 0 and SHALL be 1 in the first cycle after rst_n returns to 1.

Verification (DATA_WIDTH = 8, paired with a behavioural counter model)
REQ-042 LOAD 0x05, then RUN up to 0x0A -> cnt_load one cycle with value 0x05; exactly 5 cnt_en cycles; cnt_q = 0x0A; done with status 00 at accept+7.
REQ-043 LOAD 0xFD, then RUN up to 0x02 -> 5 enable cycles through the wrap 0xFF->0x00; final cnt_q = 0x02; status 00.
REQ-044 LOAD 0x03, then RUN down to 0x03 -> zero enable cycles; done at accept+2; status 00.
REQ-045 RUN down from 0x40 to 0x00, abort pulsed after 10 enable cycles -> cnt_q = 0x36; done with status 01; no further enable cycles.
REQ-046 cmd_op = 11 -> no counter strobes; done at accept+1 with status 10; busy is 1 for exactly one cycle.
REQ-047 rst_n = 0 in the middle of a RUN -> next cycle has all strobes 0, busy = 0, no done pulse; cmd_ready = 1 after rst_n deasserts.

Source files
------------

// File: rtl/counter_seq_ctrl.sv
// Sequences CLEAR / LOAD / RUN commands onto an external up/down counter; strobes issue the cycle after accept, done follows.
// One command at a time: cmd_ready is high only in IDLE, so offered commands simply wait while busy.
module counter_seq_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    input  logic                  cmd_dir,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] cnt_q,
    output logic                  cnt_clear,
    output logic                  cnt_load,
    output logic [DATA_WIDTH-1:0] cnt_load_val,
    output logic                  cnt_up_down,
    output logic                  cnt_en,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            status
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_LOAD  = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] OP_CLEAR = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_RUN   = 2'b10;

    localparam logic [1:0] STS_OK      = 2'b00;
    localparam logic [1:0] STS_ABORTED = 2'b01;
    localparam logic [1:0] STS_BAD_OP  = 2'b10;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  dir_q, dir_d;
    logic [1:0]            status_q, status_d;
    logic                  at_target;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            data_q   <= '0;
            dir_q    <= 1'b1;
            status_q <= STS_OK;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            dir_q    <= dir_d;
            status_q <= status_d;
        end
    end

    // The latched data doubles as the RUN target.
    assign at_target = (cnt_q == data_q);

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        dir_d     = dir_q;
        status_d  = status_q;
        cmd_ready = 1'b0;
        cnt_clear = 1'b0;
        cnt_load  = 1'b0;
        cnt_en    = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                busy      = 1'b0;
                cmd_ready = rst_n;
                if (cmd_valid && rst_n) begin
                    data_d = cmd_data;
                    dir_d  = cmd_dir;
                    unique case (cmd_op)
                        OP_CLEAR: state_d = ST_CLEAR;
                        OP_LOAD:  state_d = ST_LOAD;
                        OP_RUN:   state_d = ST_RUN;
                        default: begin
                            status_d = STS_BAD_OP;
                            state_d  = ST_DONE;
                        end
                    endcase
                end
            end
            ST_CLEAR: begin
                cnt_clear = 1'b1;
                status_d  = STS_OK;
                state_d   = ST_DONE;
            end
            ST_LOAD: begin
                cnt_load = 1'b1;
                status_d = STS_OK;
                state_d  = ST_DONE;
            end
            ST_RUN: begin
                // Reaching the target wins over a simultaneous abort.
                if (at_target) begin
                    status_d = STS_OK;
                    state_d  = ST_DONE;
                end else if (abort) begin
                    status_d = STS_ABORTED;
                    state_d  = ST_DONE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign cnt_load_val = data_q;
    assign cnt_up_down  = dir_q;
    assign status       = status_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Drives counter_seq_ctrl against a behavioural counter; each command's outcome is predicted arithmetically.
module tb_counter_seq_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [W-1:0] cmd_data;
    logic         cmd_dir;
    logic         abort;
    logic [W-1:0] cnt_q = '0;
    logic         cnt_clear;
    logic         cnt_load;
    logic [W-1:0] cnt_load_val;
    logic         cnt_up_down;
    logic         cnt_en;
    logic         busy;
    logic         done;
    logic [1:0]   status;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] model_cnt = '0;

    always #5 clk = ~clk;

    counter_seq_ctrl #(.DATA_WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_data     (cmd_data),
        .cmd_dir      (cmd_dir),
        .abort        (abort),
        .cnt_q        (cnt_q),
        .cnt_clear    (cnt_clear),
        .cnt_load     (cnt_load),
        .cnt_load_val (cnt_load_val),
        .cnt_up_down  (cnt_up_down),
        .cnt_en       (cnt_en),
        .busy         (busy),
        .done         (done),
        .status       (status)
    );

    // Behavioural counter under control of the DUT.
    always @(posedge clk) begin
        if (cnt_clear)     cnt_q <= '0;
        else if (cnt_load) cnt_q <= cnt_load_val;
        else if (cnt_en)   cnt_q <= cnt_up_down ? cnt_q + 1'b1 : cnt_q - 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [W-1:0] data, input logic dir,
                          input int abort_after);
        int           n_clr, n_ld, n_en, lat, busy_n, excl_bad, ready_bad, dir_bad, w;
        int           exp_clr, exp_ld, exp_en, exp_lat;
        logic [1:0]   st, exp_st;
        logic [W-1:0] ldv, exp_cnt, diff;
        bit           seen_done;

        n_clr = 0; n_ld = 0; n_en = 0; lat = 0; busy_n = 0;
        excl_bad = 0; ready_bad = 0; dir_bad = 0; w = 0;
        st = 2'b11; ldv = '0; seen_done = 0;
        exp_clr = 0; exp_ld = 0; exp_en = 0; exp_lat = 1; exp_st = 2'b00;
        exp_cnt = model_cnt;

        case (op)
            2'b00: begin exp_clr = 1; exp_lat = 2; exp_cnt = '0; end
            2'b01: begin exp_ld = 1; exp_lat = 2; exp_cnt = data; end
            2'b10: begin
                diff = dir ? data - model_cnt : model_cnt - data;
                if (abort_after >= 0 && abort_after < int'(diff)) begin
                    exp_en = abort_after;
                    exp_st = 2'b01;
                end else begin
                    exp_en = int'(diff);
                end
                exp_cnt = dir ? model_cnt + W'(exp_en) : model_cnt - W'(exp_en);
                exp_lat = exp_en + 2;
            end
            default: begin exp_lat = 1; exp_st = 2'b10; end
        endcase

        @(negedge clk); #1;
        while (!cmd_ready && w < 10) begin
            @(negedge clk); #1;
            w++;
        end
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_dir = dir;

        for (int c = 1; c <= 300 && !seen_done; c++) begin
            @(negedge clk);
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_op    = 2'($urandom);
            cmd_data  = W'($urandom);
            cmd_dir   = 1'($urandom);
            if (op == 2'b10) abort = (abort_after >= 0 && n_en == abort_after);
            else             abort = 1'($urandom_range(0, 1));
            #1;
            if (cnt_clear) n_clr++;
            if (cnt_load) begin n_ld++; ldv = cnt_load_val; end
            if (cnt_en) n_en++;
            if (int'(cnt_clear) + int'(cnt_load) + int'(cnt_en) > 1) excl_bad++;
            if (done && (cnt_clear || cnt_load || cnt_en)) excl_bad++;
            if (cnt_en && cnt_up_down !== dir) dir_bad++;
            if (busy) busy_n++;
            if (cmd_ready) ready_bad++;
            if (done) begin
                seen_done = 1;
                lat = c;
                st = status;
                cmd_valid = 1'b0;
                abort = 1'b0;
            end
        end
        cmd_valid = 1'b0;
        abort = 1'b0;

        check("done_seen", 32'(seen_done), 1);
        check("latency", lat, exp_lat);
        check("status", st, exp_st);
        check("clear_pulses", n_clr, exp_clr);
        check("load_pulses", n_ld, exp_ld);
        check("en_cycles", n_en, exp_en);
        check("busy_cycles", busy_n, exp_lat);
        check("strobe_excl", excl_bad, 0);
        check("ready_while_busy", ready_bad, 0);
        check("run_dir", dir_bad, 0);
        if (op == 2'b01) check("load_val", ldv, data);

        @(negedge clk); #1;
        check("cnt_final", cnt_q, exp_cnt);
        check("status_hold", status, exp_st);
        check("load_val_hold", cnt_load_val, data);
        check("idle_no_en", cnt_en, 0);
        model_cnt = cnt_q;
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; cmd_dir = 1'b0; abort = 1'b0;
        #1;
        check("ready_in_reset", cmd_ready, 0);
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_strobes", {cnt_clear, cnt_load, cnt_en, done}, 0);
        check("rst_up_down", cnt_up_down, 1);
        check("rst_load_val", cnt_load_val, 0);
        check("rst_status", status, 0);
        check("ready_in_reset2", cmd_ready, 0);
        rst_n = 1'b1;
        #1;
        check("ready_after_rst", cmd_ready, 1);

        do_cmd(2'b00, 8'h00, 1'b1, -1);
        do_cmd(2'b01, 8'h05, 1'b1, -1);
        do_cmd(2'b10, 8'h0A, 1'b1, -1);
        do_cmd(2'b01, 8'hFD, 1'b0, -1);
        do_cmd(2'b10, 8'h02, 1'b1, -1);
        do_cmd(2'b01, 8'h03, 1'b1, -1);
        do_cmd(2'b10, 8'h03, 1'b0, -1);
        do_cmd(2'b01, 8'h40, 1'b1, -1);
        do_cmd(2'b10, 8'h00, 1'b0, 10);
        do_cmd(2'b11, 8'h77, 1'b0, -1);
        do_cmd(2'b01, 8'h10, 1'b1, -1);
        do_cmd(2'b10, 8'h13, 1'b1, 3);

        for (int i = 0; i < 60; i++) begin
            logic [1:0]   op;
            logic [W-1:0] d;
            logic         dr;
            int           ab;
            op = 2'($urandom_range(0, 3));
            d  = W'($urandom);
            dr = 1'($urandom);
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : -1;
            do_cmd(op, d, dr, ab);
        end

        // Reset in the middle of a long RUN.
        @(negedge clk); #1;
        check("ready_pre_rst", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_data = model_cnt + 8'd100; cmd_dir = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("mid_run_en", cnt_en, 1);
        rst_n = 1'b0;
        @(negedge clk); #1;
        check("mrst_strobes", {cnt_clear, cnt_load, cnt_en}, 0);
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        check("mrst_ready", cmd_ready, 0);
        check("mrst_up_down", cnt_up_down, 1);
        check("mrst_load_val", cnt_load_val, 0);
        check("mrst_status", status, 0);
        rst_n = 1'b1;
        #1;
        check("mrst_ready_after", cmd_ready, 1);
        do_cmd(2'b00, 8'h5A, 1'b1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
